frame_scanout: RTL and testbench



---
 rtl/frame_scanout.sv | 138 +++++++++++++
 tb/tb_frame_scanout.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanout.sv
// Frame-buffer read-side scan engine: streams every pixel of a frame, in address
// order, from the frame buffer read port into the display pixel FIFO.
module frame_scanout #(
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              fb_re,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam int unsigned       SKID_N    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Read issued last cycle: its data is on fb_data this cycle.
    logic              pend_q;
    logic              pend_last_q;

    // Two-entry skid buffer; each entry carries an end-of-frame tag.
    logic [DATA_W-1:0] buf_data_q [SKID_N];
    logic [SKID_N-1:0] buf_last_q;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;

    logic              push;
    logic              pop;
    logic              issue_last;
    logic [1:0]        occ_after_pop;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read issue and FIFO write side
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        fb_re         = 1'b0;
        issue_last    = 1'b0;
        fifo_wr_en    = (count_q != 2'd0) && !fifo_full;
        fifo_din      = buf_data_q[rd_ptr_q];
        frame_done    = fifo_wr_en && buf_last_q[rd_ptr_q];
        busy          = (state_q != IDLE);
        push          = pend_q;
        pop           = fifo_wr_en;
        // Slots committed after this cycle's write: held pixels plus the return in flight.
        occ_after_pop = count_q - 2'(pop) + 2'(pend_q);

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (occ_after_pop < 2'(SKID_N)) begin
                    fb_re = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        issue_last = 1'b1;
                        addr_d     = '0;
                        if (!start) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((count_q == 2'd0) && !pend_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fb_addr = addr_q;

    // Address counter, read pipeline and skid buffer storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            buf_last_q  <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < int'(SKID_N); i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            addr_q      <= addr_d;
            pend_q      <= fb_re;
            pend_last_q <= issue_last;
            if (push) begin
                buf_data_q[wr_ptr_q] <= fb_data;
                buf_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout on a 16-pixel frame with a fb model returning data = address.
module tb_frame_scanout;

    localparam int unsigned FP = 16;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          fb_re;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_data = '0;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          frame_done;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    int issued = 0;
    int written = 0;
    int viol   = 0;

    logic [31:0] wq[$];
    int          wcyc[$];
    logic [31:0] dq[$];

    frame_scanout #(.FRAME_PIXELS(FP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fb_re(fb_re), .fb_addr(fb_addr), .fb_data(fb_data),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Frame buffer read port: one-cycle latency, data equals address
    always @(posedge clk) begin
        if (fb_re) fb_data <= DW'(fb_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Record one cycle at the falling edge, then advance to just after the next rising edge
    task automatic step();
        @(negedge clk);
        if (issued - written > 2) viol++;
        if (fifo_wr_en && fifo_full) viol++;
        if (frame_done && !fifo_wr_en) viol++;
        if (fifo_wr_en) begin
            wq.push_back(32'(fifo_din));
            wcyc.push_back(cyc);
            written++;
        end
        if (frame_done) dq.push_back(32'(fifo_din));
        if (fb_re) issued++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        wq.delete();
        wcyc.delete();
        dq.delete();
        issued  = 0;
        written = 0;
        base    = cyc;
    endtask

    task automatic chk_seq(input string tag, input int n);
        chk({tag, "_len"}, 32'(wq.size()), 32'(n));
        for (int i = 0; i < wq.size() && i < n; i++) begin
            chk({tag, "_val"}, wq[i], 32'(i % 16));
        end
    endtask

    task automatic chk_done(input string tag, input int n);
        chk({tag, "_done_cnt"}, 32'(dq.size()), 32'(n));
        for (int i = 0; i < dq.size(); i++) begin
            chk({tag, "_done_val"}, dq[i], 32'(FP - 1));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; fifo_full = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_fb_re", 32'(fb_re), 0);
        chk("rst_fb_addr", 32'(fb_addr), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_din", 32'(fifo_din), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        step(); step();

        // Single-frame start pulse
        clear();
        start = 1'b1; step(); start = 1'b0; #1;
        chk("t1_c1_re", 32'(fb_re), 1);
        chk("t1_c1_addr", 32'(fb_addr), 0);
        chk("t1_c1_busy", 32'(busy), 1);
        chk("t1_c1_wr", 32'(fifo_wr_en), 0);
        step(); #1;
        chk("t1_c2_addr", 32'(fb_addr), 1);
        chk("t1_c2_wr", 32'(fifo_wr_en), 0);
        step(); #1;
        chk("t1_c3_wr", 32'(fifo_wr_en), 1);
        chk("t1_c3_din", 32'(fifo_din), 0);
        repeat (15) step();
        #1;
        chk("t1_c18_done", 32'(frame_done), 1);
        chk("t1_c18_din", 32'(fifo_din), 15);
        step(); #1;
        chk("t1_c19_wr", 32'(fifo_wr_en), 0);
        chk("t1_c19_busy", 32'(busy), 1);
        step(); #1;
        chk("t1_c20_busy", 32'(busy), 0);
        repeat (5) step();
        chk_seq("t1", 16);
        chk_done("t1", 1);
        chk("t1_reads", 32'(issued), 16);
        chk("t1_first_cyc", 32'(wcyc[0] - base), 3);
        chk("t1_last_cyc", 32'(wcyc[wcyc.size()-1] - base), 18);

        // Three back-to-back frames
        clear();
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (i == 39) start = 1'b0;
        end
        chk_seq("t2", 48);
        chk_done("t2", 3);
        chk("t2_reads", 32'(issued), 48);
        chk("t2_first_cyc", 32'(wcyc[0] - base), 3);
        chk("t2_last_cyc", 32'(wcyc[wcyc.size()-1] - base), 50);
        chk("t2_busy", 32'(busy), 0);

        // Random backpressure
        clear();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            fifo_full = 1'($urandom_range(0, 1));
            step();
        end
        fifo_full = 1'b0;
        repeat (5) step();
        chk_seq("t3", 16);
        chk_done("t3", 1);
        chk("t3_viol", 32'(viol), 0);
        chk("t3_busy", 32'(busy), 0);

        // Long stall holding pixel 5
        clear();
        start = 1'b1; step(); start = 1'b0;
        repeat (7) step();
        fifo_full = 1'b1; #1;
        chk("t4_c8_wr", 32'(fifo_wr_en), 0);
        chk("t4_c8_din", 32'(fifo_din), 5);
        step(); #1;
        chk("t4_c9_din", 32'(fifo_din), 5);
        chk("t4_c9_re", 32'(fb_re), 0);
        repeat (18) step();
        #1;
        chk("t4_c27_din", 32'(fifo_din), 5);
        chk("t4_c27_re", 32'(fb_re), 0);
        chk("t4_c27_reads", 32'(issued), 7);
        step();
        fifo_full = 1'b0; #1;
        chk("t4_c28_wr", 32'(fifo_wr_en), 1);
        chk("t4_c28_din", 32'(fifo_din), 5);
        chk("t4_c28_re", 32'(fb_re), 1);
        chk("t4_c28_addr", 32'(fb_addr), 7);
        step(); #1;
        chk("t4_c29_din", 32'(fifo_din), 6);
        step(); #1;
        chk("t4_c30_wr", 32'(fifo_wr_en), 1);
        chk("t4_c30_din", 32'(fifo_din), 7);
        repeat (15) step();
        chk_seq("t4", 16);
        chk("t4_last_cyc", 32'(wcyc[wcyc.size()-1] - base), 38);

        // Reset mid-frame at pixel 9 with start held
        clear();
        start = 1'b1;
        repeat (12) step();
        rst_n = 1'b0; #1;
        chk("t5_c12_din", 32'(fifo_din), 9);
        step();
        rst_n = 1'b1;
        clear();
        #1;
        chk("t5_fb_re", 32'(fb_re), 0);
        chk("t5_fb_addr", 32'(fb_addr), 0);
        chk("t5_wr_en", 32'(fifo_wr_en), 0);
        chk("t5_din", 32'(fifo_din), 0);
        chk("t5_done", 32'(frame_done), 0);
        chk("t5_busy", 32'(busy), 0);
        step(); #1;
        chk("t5_restart_re", 32'(fb_re), 1);
        chk("t5_restart_addr", 32'(fb_addr), 0);
        for (int i = 0; i < 25; i++) begin
            step();
            if (i == 5) start = 1'b0;
        end
        chk_seq("t5", 16);
        chk("t5_reads", 32'(issued), 16);
        chk("t5_busy_end", 32'(busy), 0);

        // start dropped at pixel 3: frame still completes
        clear();
        start = 1'b1;
        repeat (6) step();
        start = 1'b0; #1;
        chk("t6_c6_din", 32'(fifo_din), 3);
        chk("t6_c6_wr", 32'(fifo_wr_en), 1);
        repeat (25) step();
        chk_seq("t6", 16);
        chk_done("t6", 1);
        chk("t6_reads", 32'(issued), 16);
        chk("t6_busy", 32'(busy), 0);
        chk("all_viol", 32'(viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
